// File: rtl/lms_sample_sequencer.sv
// Sequences buffered (x, d) pairs through a 4-tap LMS core and streams out the captured y/err results.
// Optional error monitor (err_thresh / err_alarm) is enabled by defining LMS_SEQ_ERR_MON_EN.
module lms_sample_sequencer #(
  parameter int unsigned DW         = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SETTLE     = 2
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          start,
  input  logic          abort,
  input  logic [15:0]   train_len,
  input  logic [15:0]   total_len,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_x,
  input  logic [DW-1:0] s_d,
  output logic          lms_en,
  output logic          lms_mode_train,
  output logic [DW-1:0] lms_x,
  output logic [DW-1:0] lms_d,
  input  logic [DW-1:0] lms_y,
  input  logic [DW-1:0] lms_err,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_y,
  output logic [DW-1:0] m_err,
  output logic          m_train,
  output logic          busy,
  output logic          done_irq
`ifdef LMS_SEQ_ERR_MON_EN
  ,
  input  logic [DW-1:0] err_thresh,
  output logic          err_alarm
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SET_W = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [DW-1:0]    r_mem_x [FIFO_DEPTH];
  logic [DW-1:0]    r_mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_fcnt;
  logic [15:0]      r_train_len;
  logic [15:0]      r_total_len;
  logic [15:0]      r_count;
  logic [SET_W-1:0] r_settle;
  logic             r_lms_en;
  logic             r_lms_mode_train;
  logic [DW-1:0]    r_lms_x;
  logic [DW-1:0]    r_lms_d;
  logic             r_m_valid;
  logic [DW-1:0]    r_m_y;
  logic [DW-1:0]    r_m_err;
  logic             r_m_train;
  logic             r_done_irq;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_last;

  assign w_full  = (r_fcnt == CNT_W'(FIFO_DEPTH));
  assign w_empty = (r_fcnt == '0);
  // Abort takes priority over any FIFO traffic in the same cycle.
  assign w_push  = s_valid && !w_full && !abort;
  assign w_pop   = (r_state == S_FEED) && !w_empty && !abort;
  assign w_last  = (({1'b0, r_count} + 17'd1) == {1'b0, r_total_len});

  always_ff @(posedge Clk) begin
    if (w_push) begin
      r_mem_x[r_wptr] <= s_x;
      r_mem_d[r_wptr] <= s_d;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else if (abort) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_fcnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_fcnt <= r_fcnt + CNT_W'(1);
        2'b01:   r_fcnt <= r_fcnt - CNT_W'(1);
        default: r_fcnt <= r_fcnt;
      endcase
    end
  end

`ifdef LMS_SEQ_ERR_MON_EN
  logic          r_err_alarm;
  logic [DW-1:0] w_err_abs;
  logic          w_alarm_hit;

  // Magnitude of lms_err; the most negative value saturates to the largest positive one.
  always_comb begin
    w_err_abs = lms_err;
    if (lms_err[DW-1]) begin
      if (lms_err == {1'b1, {(DW-1){1'b0}}}) w_err_abs = {1'b0, {(DW-1){1'b1}}};
      else                                   w_err_abs = DW'(~lms_err + DW'(1));
    end
  end

  assign w_alarm_hit = !r_lms_mode_train && (w_err_abs > err_thresh);
  assign err_alarm   = r_err_alarm;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state          <= S_IDLE;
      r_train_len      <= '0;
      r_total_len      <= '0;
      r_count          <= '0;
      r_settle         <= '0;
      r_lms_en         <= 1'b0;
      r_lms_mode_train <= 1'b0;
      r_lms_x          <= '0;
      r_lms_d          <= '0;
      r_m_valid        <= 1'b0;
      r_m_y            <= '0;
      r_m_err          <= '0;
      r_m_train        <= 1'b0;
      r_done_irq       <= 1'b0;
`ifdef LMS_SEQ_ERR_MON_EN
      r_err_alarm      <= 1'b0;
`endif
    end else begin
      r_lms_en   <= 1'b0;
      r_done_irq <= 1'b0;
      if (abort) begin
        r_state   <= S_IDLE;
        r_m_valid <= 1'b0;
`ifdef LMS_SEQ_ERR_MON_EN
        r_err_alarm <= 1'b0;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
`ifdef LMS_SEQ_ERR_MON_EN
              r_err_alarm <= 1'b0;
`endif
              if (total_len != 16'd0) begin
                r_train_len <= train_len;
                r_total_len <= total_len;
                r_count     <= '0;
                r_state     <= S_FEED;
              end else begin
                r_done_irq <= 1'b1;
              end
            end
          end
          S_FEED: begin
            if (!w_empty) begin
              r_lms_x          <= r_mem_x[r_rptr];
              r_lms_d          <= r_mem_d[r_rptr];
              r_lms_mode_train <= (r_count < r_train_len);
              r_lms_en         <= 1'b1;
              r_settle         <= SET_W'(SETTLE);
              r_state          <= S_WAIT;
            end
          end
          S_WAIT: begin
            // Capture once the counter has expired: SETTLE+1 cycles after the strobe.
            if (r_settle == '0) begin
              r_m_y     <= lms_y;
              r_m_err   <= lms_err;
              r_m_train <= r_lms_mode_train;
              r_m_valid <= 1'b1;
              r_state   <= S_EMIT;
`ifdef LMS_SEQ_ERR_MON_EN
              if (w_alarm_hit) r_err_alarm <= 1'b1;
`endif
            end else begin
              r_settle <= r_settle - SET_W'(1);
            end
          end
          S_EMIT: begin
            if (m_ready) begin
              r_m_valid <= 1'b0;
              r_count   <= r_count + 16'd1;
              if (w_last) begin
                r_state    <= S_DONE;
                r_done_irq <= 1'b1;
              end else begin
                r_state <= S_FEED;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign s_ready        = !w_full;
  assign lms_en         = r_lms_en;
  assign lms_mode_train = r_lms_mode_train;
  assign lms_x          = r_lms_x;
  assign lms_d          = r_lms_d;
  assign m_valid        = r_m_valid;
  assign m_y            = r_m_y;
  assign m_err          = r_m_err;
  assign m_train        = r_m_train;
  assign busy           = (r_state != S_IDLE);
  assign done_irq       = r_done_irq;

endmodule

// File: tb/tb_lms_sample_sequencer.sv
// Directed bench for lms_sample_sequencer with a trivial LMS stand-in (y = x + 7, err = d - x).
module tb_lms_sample_sequencer;

  localparam int DW     = 16;
  localparam int SETTLE = 2;

  logic          Clk = 1'b0;
  logic          Rst;
  logic          start;
  logic          abort;
  logic [15:0]   train_len;
  logic [15:0]   total_len;
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_x;
  logic [DW-1:0] s_d;
  logic          lms_en;
  logic          lms_mode_train;
  logic [DW-1:0] lms_x;
  logic [DW-1:0] lms_d;
  logic [DW-1:0] lms_y;
  logic [DW-1:0] lms_err;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_y;
  logic [DW-1:0] m_err;
  logic          m_train;
  logic          busy;
  logic          done_irq;
`ifdef LMS_SEQ_ERR_MON_EN
  logic [DW-1:0] err_thresh;
  logic          err_alarm;
`endif

  lms_sample_sequencer #(.DW(DW), .FIFO_DEPTH(4), .SETTLE(SETTLE)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .abort(abort),
    .train_len(train_len), .total_len(total_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_d(s_d),
    .lms_en(lms_en), .lms_mode_train(lms_mode_train), .lms_x(lms_x), .lms_d(lms_d),
    .lms_y(lms_y), .lms_err(lms_err),
    .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_err(m_err), .m_train(m_train),
    .busy(busy), .done_irq(done_irq)
`ifdef LMS_SEQ_ERR_MON_EN
    , .err_thresh(err_thresh), .err_alarm(err_alarm)
`endif
  );

  always #5 Clk = ~Clk;

  assign lms_y   = lms_x + DW'(7);
  assign lms_err = lms_d - lms_x;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic prev_mv = 1'b0;
  int en_cyc[$], en_mode[$], en_x[$], mv_cyc[$];
  int res_y[$], res_err[$], res_train[$];

  always @(posedge Clk) cyc <= cyc + 1;

  // Record strobes, result acceptances and interrupts mid-cycle.
  always @(negedge Clk) begin
    if (lms_en) begin
      en_cyc.push_back(cyc);
      en_mode.push_back(int'(lms_mode_train));
      en_x.push_back(int'($signed(lms_x)));
    end
    if (m_valid && !prev_mv) mv_cyc.push_back(cyc);
    prev_mv = m_valid;
    if (m_valid && m_ready) begin
      res_y.push_back(int'($signed(m_y)));
      res_err.push_back(int'($signed(m_err)));
      res_train.push_back(int'(m_train));
    end
    if (done_irq) done_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -999999;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input int x, input int d);
    s_valid = 1'b1;
    s_x     = DW'(x);
    s_d     = DW'(d);
    tick();
    s_valid = 1'b0;
  endtask

  task automatic go(input int tl, input int tot);
    train_len = 16'(tl);
    total_len = 16'(tot);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int target, input string tag);
    for (int i = 0; i < 300 && done_cnt < target; i++) tick();
    check(tag, done_cnt, target);
  endtask

  task automatic clr();
    en_cyc.delete(); en_mode.delete(); en_x.delete(); mv_cyc.delete();
    res_y.delete(); res_err.delete(); res_train.delete();
    done_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int exp_y1[4]  = '{107, 207, 307, 407};
    int exp_e1[4]  = '{10, -10, 30, -20};
    int exp_m1[4]  = '{1, 1, 0, 0};
    int exp_y2[3]  = '{2, 1007, -32762};
    int exp_e2[3]  = '{25, -2000, -32767};

    Rst = 1'b1; start = 1'b0; abort = 1'b0; s_valid = 1'b0; m_ready = 1'b1;
    train_len = '0; total_len = '0; s_x = '0; s_d = '0;
`ifdef LMS_SEQ_ERR_MON_EN
    err_thresh = DW'(100);
`endif
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;
    tick();

    // Reset state
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_m_valid", int'(m_valid), 0);
    check("rst_lms_en", int'(lms_en), 0);
    check("rst_done_irq", int'(done_irq), 0);
    check("rst_lms_x", int'(lms_x), 0);
    check("rst_m_y", int'(m_y), 0);

    // Zero-length block: immediate interrupt, never busy
    go(0, 0);
    check("zero_done_irq", int'(done_irq), 1);
    check("zero_busy", int'(busy), 0);
    tick();
    check("zero_done_low", int'(done_irq), 0);

    // Basic block: 2 training + 2 run samples
    clr();
    push(100, 110); push(200, 190); push(300, 330); push(400, 380);
    check("t1_full_sready", int'(s_ready), 0);
    go(2, 4);
    wait_done(1, "t1_done");
    check("t1_en_cnt", en_cyc.size(), 4);
    check("t1_res_cnt", res_y.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_mode%0d", i), qat(en_mode, i), exp_m1[i]);
      check($sformatf("t1_y%0d", i), qat(res_y, i), exp_y1[i]);
      check($sformatf("t1_err%0d", i), qat(res_err, i), exp_e1[i]);
      check($sformatf("t1_train%0d", i), qat(res_train, i), exp_m1[i]);
      check($sformatf("t1_lat%0d", i), qat(mv_cyc, i) - qat(en_cyc, i), SETTLE + 1);
    end
    tick();
    check("t1_busy_low", int'(busy), 0);
    check("t1_done_once", done_cnt, 1);

    // Starved FIFO: FEED stalls and lms_x holds; start while busy ignored
    clr();
    go(5, 3);
    repeat (3) tick();
    check("t2_stall_en", en_cyc.size(), 0);
    check("t2_stall_busy", int'(busy), 1);
    push(-5, 20);
    repeat (10) tick();
    check("t2_res1", res_y.size(), 1);
    check("t2_x_hold", int'($signed(lms_x)), -5);
    check("t2_en_low", int'(lms_en), 0);
    go(0, 1);
    push(1000, -1000);
    repeat (10) tick();
    check("t2_busy_mid", int'(busy), 1);
    push(32767, 0);
    wait_done(1, "t2_done");
    check("t2_res_cnt", res_y.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_y%0d", i), qat(res_y, i), exp_y2[i]);
      check($sformatf("t2_err%0d", i), qat(res_err, i), exp_e2[i]);
      check($sformatf("t2_train%0d", i), qat(res_train, i), 1);
    end

    // Back-pressure on the result stream
    clr();
    m_ready = 1'b0;
    push(50, 60); push(-50, -70);
    go(0, 2);
    for (int i = 0; i < 50 && !m_valid; i++) tick();
    check("t3_mvalid", int'(m_valid), 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_y", int'($signed(m_y)), 57);
      check("t3_hold_err", int'($signed(m_err)), 10);
      check("t3_hold_valid", int'(m_valid), 1);
      check("t3_hold_en", en_cyc.size(), 1);
    end
    m_ready = 1'b1;
    wait_done(1, "t3_done");
    check("t3_res_cnt", res_y.size(), 2);
    check("t3_y0", qat(res_y, 0), 57);
    check("t3_y1", qat(res_y, 1), -43);
    check("t3_err1", qat(res_err, 1), -20);
    check("t3_train1", qat(res_train, 1), 0);

    // FIFO full: s_ready drops after four pushes, no overwrite
    clr();
    s_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      s_x = DW'(10 + i);
      s_d = '0;
      check($sformatf("t4_sready%0d", i), int'(s_ready), int'(i < 4));
      tick();
    end
    s_valid = 1'b0;
    go(0, 2);
    wait_done(1, "t4_done");
    check("t4_y0", qat(res_y, 0), 17);
    check("t4_y1", qat(res_y, 1), 18);
    check("t4_sready_after", int'(s_ready), 1);

    // Push and pop in the same cycle
    clr();
    train_len = 16'd0; total_len = 16'd3; start = 1'b1;
    tick();
    start = 1'b0; s_valid = 1'b1; s_x = DW'(14); s_d = '0;
    tick();
    s_valid = 1'b0;
    wait_done(1, "t4b_done");
    check("t4b_y0", qat(res_y, 0), 19);
    check("t4b_y1", qat(res_y, 1), 20);
    check("t4b_y2", qat(res_y, 2), 21);

    // Abort during WAIT of sample 2 of 5, with a competing push and start
    clr();
    push(1, 0); push(2, 0); push(3, 0); push(4, 0);
    go(1, 5);
    for (int i = 0; i < 100 && en_cyc.size() < 2; i++) @(negedge Clk);
    #1;
    abort = 1'b1; s_valid = 1'b1; s_x = DW'(99); start = 1'b1;
    tick();
    abort = 1'b0; s_valid = 1'b0; start = 1'b0;
    check("t5_busy", int'(busy), 0);
    check("t5_m_valid", int'(m_valid), 0);
    check("t5_lms_en", int'(lms_en), 0);
    check("t5_sready", int'(s_ready), 1);
    check("t5_en_cnt", en_cyc.size(), 2);
    check("t5_mode1", qat(en_mode, 1), 0);
    repeat (10) tick();
    check("t5_no_irq", done_cnt, 0);
    check("t5_res_cnt", res_y.size(), 1);
    clr();
    go(0, 2);
    push(7, 0); push(8, 0);
    wait_done(1, "t5_new_done");
    check("t5_new_cnt", res_y.size(), 2);
    check("t5_new_y0", qat(res_y, 0), 14);
    check("t5_new_y1", qat(res_y, 1), 15);

`ifdef LMS_SEQ_ERR_MON_EN
    // Error monitor: training errors ignored, run errors beyond threshold latch
    clr();
    err_thresh = DW'(100);
    push(0, 500); push(0, -101);
    go(1, 2);
    for (int i = 0; i < 50 && res_y.size() < 1; i++) tick();
    check("t6_alarm_train", int'(err_alarm), 0);
    wait_done(1, "t6_done");
    check("t6_alarm_set", int'(err_alarm), 1);
    repeat (3) tick();
    check("t6_alarm_sticky", int'(err_alarm), 1);
    go(0, 0);
    check("t6_alarm_clr", int'(err_alarm), 0);
    clr();
    err_thresh = DW'(16'h7FFF);
    push(0, -32768);
    go(0, 1);
    wait_done(1, "t6_sat_done");
    check("t6_alarm_sat", int'(err_alarm), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
